// File: rtl/any1_issue_if.sv
// Handshake bundle between the scheduler/ROB side, the issue stage and the
// execute unit. The master modport is the issue stage itself.
interface any1_issue_if #(
  parameter int ROB_ENTRIES = 64,
  parameter int PAYLOAD_W   = 256
);
  localparam int RID_W = $clog2(ROB_ENTRIES);

  logic [RID_W:0]       selection;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic                 sel_stall;
  logic                 ex_valid;
  logic [RID_W-1:0]     ex_rid;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic                 ex_ready;
  logic                 out_set_v;
  logic [RID_W-1:0]     out_set_rid;

  modport master (
    input  selection, sel_payload, ex_ready,
    output sel_stall, ex_valid, ex_rid, ex_payload, out_set_v, out_set_rid
  );

  modport slave (
    output selection, sel_payload, ex_ready,
    input  sel_stall, ex_valid, ex_rid, ex_payload, out_set_v, out_set_rid
  );
endinterface

// File: rtl/any1_issue_stage.sv
// ANY-1 issue stage: 2-entry skid buffer between the scheduler and the
// execute unit, with mark-out pulses back to the ROB.
//
// state | meaning
// EMPTY | no entries queued, ex_valid low
// ONE   | s0 holds the head entry
// FULL  | s0 is the head, s1 the next entry; no space unless s0 pops
module any1_issue_stage #(
  parameter int ROB_ENTRIES = 64,
  parameter int PAYLOAD_W   = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  any1_issue_if.master bus,
  output logic [31:0]  issue_count,
  output logic [31:0]  drop_count
);
  localparam int RID_W = $clog2(ROB_ENTRIES);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [RID_W-1:0]     s0_rid;
  logic [RID_W-1:0]     s1_rid;
  logic [PAYLOAD_W-1:0] s0_pay;
  logic [PAYLOAD_W-1:0] s1_pay;

  logic [RID_W-1:0] sel_rid;
  logic             vsel;
  logic             dup;
  logic             space;
  logic             pop;
  logic             push;
  logic             ld_s0_new;
  logic             ld_s0_s1;
  logic             ld_s1_new;

  assign sel_rid = bus.selection[RID_W-1:0];
  assign vsel    = ~bus.selection[RID_W];
  assign pop     = bus.ex_valid & bus.ex_ready;
  // Compare against slots occupied before the edge, including a slot being popped.
  assign dup     = ((state != EMPTY) && (s0_rid == sel_rid)) ||
                   ((state == FULL) && (s1_rid == sel_rid));
  assign space   = (state != FULL) | pop;
  assign push    = vsel & ~dup & space & ~flush;

  assign bus.sel_stall  = vsel & ~push;
  assign bus.ex_valid   = (state != EMPTY);
  assign bus.ex_rid     = s0_rid;
  assign bus.ex_payload = s0_pay;

  // Next-state and slot load selects; flush empties the buffer unconditionally.
  always_comb begin
    state_nxt = state;
    ld_s0_new = 1'b0;
    ld_s0_s1  = 1'b0;
    ld_s1_new = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            ld_s0_new = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_nxt = FULL;
            ld_s1_new = 1'b1;
          end else if (push && pop) begin
            ld_s0_new = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop && push) begin
            ld_s0_s1  = 1'b1;
            ld_s1_new = 1'b1;
          end else if (pop) begin
            state_nxt = ONE;
            ld_s0_s1  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Slot storage; s0 feeds the execute unit directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_rid <= '0;
      s0_pay <= '0;
      s1_rid <= '0;
      s1_pay <= '0;
    end else begin
      if (ld_s0_new) begin
        s0_rid <= sel_rid;
        s0_pay <= bus.sel_payload;
      end else if (ld_s0_s1) begin
        s0_rid <= s1_rid;
        s0_pay <= s1_pay;
      end
      if (ld_s1_new) begin
        s1_rid <= sel_rid;
        s1_pay <= bus.sel_payload;
      end
    end
  end

  // Mark-out pulse one cycle after each accepted selection; rid holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_set_v   <= 1'b0;
      bus.out_set_rid <= '0;
    end else begin
      bus.out_set_v <= push;
      if (push) bus.out_set_rid <= sel_rid;
    end
  end

  // Handshake and rejection counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= '0;
      drop_count  <= '0;
    end else begin
      if (pop)           issue_count <= issue_count + 32'd1;
      if (bus.sel_stall) drop_count  <= drop_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_any1_issue_stage.sv
// Self-checking bench for any1_issue_stage: directed scenario tasks plus a
// queue scoreboard that predicts acceptance and checks the issue stream.
module tb_any1_issue_stage;
  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] issue_count;
  logic [31:0] drop_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]   rid;
    logic [255:0] pay;
  } ent_t;

  ent_t sb[$];
  int   m_issue;
  int   m_drop;
  logic m_prev_push;
  logic [5:0] m_prev_rid;

  any1_issue_if #(.ROB_ENTRIES(64), .PAYLOAD_W(256)) bus ();

  any1_issue_stage #(.ROB_ENTRIES(64), .PAYLOAD_W(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .issue_count (issue_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand_pay();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic drive(input logic [6:0] sel, input logic fl, input logic rdy);
    bus.selection   = sel;
    bus.sel_payload = rand_pay();
    flush           = fl;
    bus.ex_ready    = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.selection = 7'h40;
    flush = 1'b0;
    bus.ex_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard: samples mid-cycle, compares the DUT against the queue model,
  // then advances the model as the coming edge will.
  task automatic monitor();
    logic m_pop, vs, dp, acc;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        m_issue = 0;
        m_drop = 0;
        m_prev_push = 1'b0;
        m_prev_rid = '0;
      end else begin
        checks++;
        if (bus.ex_valid !== (sb.size() != 0)) begin
          failures++;
          $display("FAIL sb_ex_valid: got %0b expected %0b", bus.ex_valid, sb.size() != 0);
        end
        if (sb.size() != 0) begin
          checks++;
          if (bus.ex_rid !== sb[0].rid) begin
            failures++;
            $display("FAIL sb_ex_rid: got %0h expected %0h", bus.ex_rid, sb[0].rid);
          end
          checks++;
          if (bus.ex_payload !== sb[0].pay) begin
            failures++;
            $display("FAIL sb_ex_payload: got %0h expected %0h", bus.ex_payload, sb[0].pay);
          end
        end
        checks++;
        if (bus.out_set_v !== m_prev_push) begin
          failures++;
          $display("FAIL sb_out_set_v: got %0b expected %0b", bus.out_set_v, m_prev_push);
        end
        checks++;
        if (bus.out_set_rid !== m_prev_rid) begin
          failures++;
          $display("FAIL sb_out_set_rid: got %0h expected %0h", bus.out_set_rid, m_prev_rid);
        end
        checks++;
        if (issue_count !== 32'(m_issue) || drop_count !== 32'(m_drop)) begin
          failures++;
          $display("FAIL sb_counters: got issue=%0d drop=%0d expected issue=%0d drop=%0d",
                   issue_count, drop_count, m_issue, m_drop);
        end
        m_pop = (sb.size() != 0) && bus.ex_ready;
        vs = !bus.selection[6];
        dp = 1'b0;
        foreach (sb[i]) if (sb[i].rid == bus.selection[5:0]) dp = 1'b1;
        acc = vs && !dp && ((sb.size() < 2) || m_pop) && !flush;
        checks++;
        if (bus.sel_stall !== (vs && !acc)) begin
          failures++;
          $display("FAIL sb_sel_stall: got %0b expected %0b", bus.sel_stall, vs && !acc);
        end
        if (m_pop) begin
          void'(sb.pop_front());
          m_issue++;
        end
        if (flush) sb.delete();
        else if (acc) sb.push_back('{rid: bus.selection[5:0], pay: bus.sel_payload});
        if (vs && !acc) m_drop++;
        m_prev_push = acc;
        if (acc) m_prev_rid = bus.selection[5:0];
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rid !== 6'd0 || bus.ex_payload !== '0 ||
        bus.out_set_v !== 1'b0 || bus.out_set_rid !== 6'd0 ||
        issue_count !== 32'd0 || drop_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_values: got v=%0b rid=%0h osv=%0b osr=%0h ic=%0d dc=%0d expected all zero",
               bus.ex_valid, bus.ex_rid, bus.out_set_v, bus.out_set_rid, issue_count, drop_count);
    end
    drive(7'h0B, 1'b0, 1'b1); step();
    drive(7'h01, 1'b0, 1'b1); step();
    drive(7'h02, 1'b0, 1'b0); step();
    drive(7'h03, 1'b0, 1'b0); step();
    checks++;
    if (issue_count !== 32'd1 || drop_count !== 32'd1) begin
      failures++;
      $display("FAIL reset_pre_counts: got ic=%0d dc=%0d expected ic=1 dc=1", issue_count, drop_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || issue_count !== 32'd0 || drop_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: got v=%0b ic=%0d dc=%0d expected v=0 ic=0 dc=0",
               bus.ex_valid, issue_count, drop_count);
    end
    checks++;
    if (bus.ex_rid !== 6'd0 || bus.ex_payload !== '0 || bus.out_set_rid !== 6'd0) begin
      failures++;
      $display("FAIL reset_async_regs: got rid=%0h osr=%0h expected 0 0", bus.ex_rid, bus.out_set_rid);
    end
    step();
    checks++;
    if (bus.out_set_v !== 1'b0 || bus.ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_push: got osv=%0b v=%0b expected 0 0", bus.out_set_v, bus.ex_valid);
    end
    bus.selection = 7'h40;
    rst = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_set_v !== 1'b0 || bus.ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got osv=%0b v=%0b expected 0 0", bus.out_set_v, bus.ex_valid);
    end
  endtask

  task automatic test_single_issue();
    apply_reset();
    drive(7'h05, 1'b0, 1'b1); step();
    drive(7'h40, 1'b0, 1'b1);
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rid !== 6'h05) begin
      failures++;
      $display("FAIL single_head: got v=%0b rid=%0h expected v=1 rid=5", bus.ex_valid, bus.ex_rid);
    end
    checks++;
    if (bus.out_set_v !== 1'b1 || bus.out_set_rid !== 6'h05) begin
      failures++;
      $display("FAIL single_out_set: got v=%0b rid=%0h expected v=1 rid=5", bus.out_set_v, bus.out_set_rid);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || issue_count !== 32'd1) begin
      failures++;
      $display("FAIL single_done: got v=%0b ic=%0d expected v=0 ic=1", bus.ex_valid, issue_count);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive(7'h03, 1'b0, 1'b0);
    checks++;
    if (bus.sel_stall !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept3: got stall=%0b expected 0", bus.sel_stall);
    end
    step();
    drive(7'h04, 1'b0, 1'b0);
    checks++;
    if (bus.sel_stall !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept4: got stall=%0b expected 0", bus.sel_stall);
    end
    step();
    drive(7'h06, 1'b0, 1'b0);
    checks++;
    if (bus.sel_stall !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall6: got stall=%0b expected 1", bus.sel_stall);
    end
    step();
    checks++;
    if (drop_count !== 32'd1 || bus.out_set_v !== 1'b0) begin
      failures++;
      $display("FAIL bp_drop: got dc=%0d osv=%0b expected dc=1 osv=0", drop_count, bus.out_set_v);
    end
    drive(7'h40, 1'b0, 1'b1);
    checks++;
    if (bus.ex_rid !== 6'h03) begin
      failures++;
      $display("FAIL bp_order_first: got %0h expected 3", bus.ex_rid);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rid !== 6'h04) begin
      failures++;
      $display("FAIL bp_order_second: got v=%0b rid=%0h expected v=1 rid=4", bus.ex_valid, bus.ex_rid);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || issue_count !== 32'd2) begin
      failures++;
      $display("FAIL bp_drain: got v=%0b ic=%0d expected v=0 ic=2", bus.ex_valid, issue_count);
    end
  endtask

  task automatic test_full_pop();
    apply_reset();
    drive(7'h03, 1'b0, 1'b0); step();
    drive(7'h04, 1'b0, 1'b0); step();
    drive(7'h07, 1'b0, 1'b1);
    checks++;
    if (bus.sel_stall !== 1'b0 || bus.ex_rid !== 6'h03) begin
      failures++;
      $display("FAIL fullpop_accept: got stall=%0b rid=%0h expected stall=0 rid=3", bus.sel_stall, bus.ex_rid);
    end
    step();
    checks++;
    if (bus.ex_rid !== 6'h04 || bus.out_set_v !== 1'b1 || bus.out_set_rid !== 6'h07) begin
      failures++;
      $display("FAIL fullpop_next: got rid=%0h osv=%0b osr=%0h expected rid=4 osv=1 osr=7",
               bus.ex_rid, bus.out_set_v, bus.out_set_rid);
    end
    drive(7'h40, 1'b0, 1'b1); step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rid !== 6'h07) begin
      failures++;
      $display("FAIL fullpop_last: got v=%0b rid=%0h expected v=1 rid=7", bus.ex_valid, bus.ex_rid);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || issue_count !== 32'd3) begin
      failures++;
      $display("FAIL fullpop_drain: got v=%0b ic=%0d expected v=0 ic=3", bus.ex_valid, issue_count);
    end
  endtask

  task automatic test_duplicate();
    apply_reset();
    drive(7'h09, 1'b0, 1'b0); step();
    drive(7'h09, 1'b0, 1'b0);
    checks++;
    if (bus.sel_stall !== 1'b1) begin
      failures++;
      $display("FAIL dup_s0: got stall=%0b expected 1", bus.sel_stall);
    end
    step();
    checks++;
    if (drop_count !== 32'd1 || bus.out_set_v !== 1'b0 || bus.ex_rid !== 6'h09) begin
      failures++;
      $display("FAIL dup_s0_after: got dc=%0d osv=%0b rid=%0h expected dc=1 osv=0 rid=9",
               drop_count, bus.out_set_v, bus.ex_rid);
    end
    drive(7'h0C, 1'b0, 1'b0); step();
    drive(7'h0C, 1'b0, 1'b1);
    checks++;
    if (bus.sel_stall !== 1'b1) begin
      failures++;
      $display("FAIL dup_s1_pop: got stall=%0b expected 1", bus.sel_stall);
    end
    drive(7'h09, 1'b0, 1'b1);
    checks++;
    if (bus.sel_stall !== 1'b1) begin
      failures++;
      $display("FAIL dup_popped_slot: got stall=%0b expected 1", bus.sel_stall);
    end
    step();
    checks++;
    if (drop_count !== 32'd2 || bus.out_set_v !== 1'b0 || bus.ex_rid !== 6'h0C) begin
      failures++;
      $display("FAIL dup_after_pop: got dc=%0d osv=%0b rid=%0h expected dc=2 osv=0 rid=c",
               drop_count, bus.out_set_v, bus.ex_rid);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    drive(7'h01, 1'b0, 1'b0); step();
    drive(7'h02, 1'b0, 1'b0); step();
    drive(7'h0A, 1'b1, 1'b0);
    checks++;
    if (bus.sel_stall !== 1'b1) begin
      failures++;
      $display("FAIL flush_stall: got stall=%0b expected 1", bus.sel_stall);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.out_set_v !== 1'b0 || drop_count !== 32'd1) begin
      failures++;
      $display("FAIL flush_empty: got v=%0b osv=%0b dc=%0d expected v=0 osv=0 dc=1",
               bus.ex_valid, bus.out_set_v, drop_count);
    end
    drive(7'h05, 1'b0, 1'b0); step();
    drive(7'h0B, 1'b1, 1'b1); step();
    checks++;
    if (issue_count !== 32'd1 || bus.ex_valid !== 1'b0 || bus.out_set_v !== 1'b0 || drop_count !== 32'd2) begin
      failures++;
      $display("FAIL flush_with_pop: got ic=%0d v=%0b osv=%0b dc=%0d expected ic=1 v=0 osv=0 dc=2",
               issue_count, bus.ex_valid, bus.out_set_v, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(7'(7'h10 + i), 1'b0, 1'b1);
      checks++;
      if (bus.sel_stall !== 1'b0) begin
        failures++;
        $display("FAIL b2b_stall: got %0b expected 0 at i=%0d", bus.sel_stall, i);
      end
      if (i > 0) begin
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rid !== 6'(6'h10 + i - 1)) begin
          failures++;
          $display("FAIL b2b_head: got v=%0b rid=%0h expected v=1 rid=%0h",
                   bus.ex_valid, bus.ex_rid, 6'(6'h10 + i - 1));
        end
      end
      step();
    end
    drive(7'h40, 1'b0, 1'b1); step();
    checks++;
    if (issue_count !== 32'd8 || drop_count !== 32'd0 || bus.ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_totals: got ic=%0d dc=%0d v=%0b expected ic=8 dc=0 v=0",
               issue_count, drop_count, bus.ex_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.selection = 7'h40;
    bus.sel_payload = '0;
    bus.ex_ready = 1'b0;
    m_issue = 0;
    m_drop = 0;
    m_prev_push = 1'b0;
    m_prev_rid = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_issue();
    test_backpressure();
    test_full_pop();
    test_duplicate();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/any1_issue_stage.md
# any1_issue_stage

Issue buffer directly downstream of the ANY-1 instruction scheduler. Each cycle it takes the scheduler's 7-bit selection and the ROB payload of the selected entry, and queues the pair in a 2-entry skid buffer. It presents the oldest queued instruction to the execute unit with a valid/ready handshake. It also emits a one-cycle "mark out" pulse back to the ROB for every accepted selection, and rejects duplicate or flushed selections.

## Interface
- `ROB_ENTRIES`, 64: ROB depth; rid width is `$clog2(ROB_ENTRIES)` = 6.
- `PAYLOAD_W`, 256: width of the per-entry payload (opcode, operands, immediates), read combinationally by the parent from ROB[selection[5:0]].
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `selection`  in  7  scheduler output. Bit 6 = 1 means no selection. Bits [5:0] = rid.
- `sel_payload`  in  PAYLOAD_W  payload of ROB[selection[5:0]], same cycle.
- `flush`  in  1  synchronous pipeline flush (branch miss or exception).
- `ex_valid`  out  1  head entry is valid for the execute unit.
- `ex_rid`  out  6  rid of the head entry.
- `ex_payload`  out  PAYLOAD_W  payload of the head entry.
- `ex_ready`  in  1  execute unit accepts the head entry this cycle.
- `out_set_v`  out  1  one-cycle pulse: set the `out` flag of ROB[`out_set_rid`].
- `out_set_rid`  out  6  rid to mark out.
- `sel_stall`  out  1  combinational; the current valid selection is not accepted this cycle.
- `issue_count`  out  32  number of handshakes completed since reset.
- `drop_count`  out  32  number of valid selections rejected since reset (stall, duplicate or flush).

## Operation
- Storage: two slots, `s0` (head) and `s1`, each holding {rid, payload}, plus `cnt` ∈ {0,1,2}. The states are EMPTY (cnt=0), ONE (cnt=1) and FULL (cnt=2).
- `pop` = `ex_valid & ex_ready`.
- `vsel` = `!selection[6]`.
- `dup` = the selection rid equals the rid of any occupied slot.
- `space` = `cnt<2 | pop`.
- `push` = `vsel & !dup & space & !flush`.
- `sel_stall` = `vsel & !push`.
- State transitions:
  - EMPTY: push → ONE, with the new entry in s0.
  - ONE: push & !pop → FULL (new entry in s1). push & pop → ONE (new entry in s0). pop only → EMPTY.
  - FULL: pop & push → FULL, with s1 moving to s0 and the new entry in s1. pop only → ONE, with s1 moving to s0. Otherwise hold.
- `flush` takes priority over everything:
  - cnt ← 0 at the next edge, with no push.
  - A handshake that completes in the flush cycle still counts in `issue_count`.
- `out_set_v` is registered: it equals `push` of the previous cycle, and `out_set_rid` equals that cycle's rid. When no push occurred, `out_set_rid` holds its previous value.
- A rejected selection (`sel_stall`) generates no `out_set` pulse. The entry stays not-out in the ROB, so the scheduler may select it again.
- `ex_valid` = `cnt!=0`. `ex_rid` and `ex_payload` are driven directly from s0 registers, with no combinational path from `selection`.
- Slot contents are don't-care when unoccupied. The payload is never modified in this block.
- Counters are 32-bit and wrap modulo 2^32:
  - `issue_count` increments on each `pop`.
  - `drop_count` increments on each `sel_stall`.

## Timing
- Reset values: cnt=0, `ex_valid`=0, `ex_rid`=0, `ex_payload`=0, `out_set_v`=0, `out_set_rid`=0, both counters 0, all slot registers 0.
- Reset is asynchronous: asserting `rst` mid-operation clears all state immediately, without waiting for a clock edge. Nothing is pushed while `rst`=1.
- Latency: a selection accepted at edge N gives:
  - `out_set_v`=1 in cycle N+1;
  - `ex_valid`=1 in cycle N+1 if the buffer was EMPTY, or if it was ONE with a pop at edge N.
- With `ex_ready` held at 1, the block sustains one issue per cycle.
- Simultaneous events: in FULL with pop and a valid selection in the same cycle, the selection is accepted (no stall). Duplicate detection compares only against slots occupied before the edge, including the slot being popped.
- Once a handshake completes, the payload must not change before the edge (it is registered).

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` asynchronously mid-cycle with cnt=2.
  - Response: `ex_valid`=0 and both counters=0 immediately. With `selection`=7'h40 afterwards, `out_set_v` stays 0.
- Single issue:
  - Stimulus: `selection`=7'h05 at edge 1, `ex_ready`=1.
  - Response: cycle 2 shows `ex_valid`=1, `ex_rid`=5, `out_set_v`=1, `out_set_rid`=5. Cycle 3 shows `ex_valid`=0 and `issue_count`=1.
- Backpressure:
  - Stimulus: `ex_ready`=0; select rids 3, 4, 6 on consecutive cycles.
  - Response: 3 and 4 are accepted. For 6, `sel_stall`=1, `drop_count`=1 and no `out_set` pulse. After raising `ex_ready`, the issue order is 3 then 4.
- Full with pop:
  - Stimulus: buffer holds {3, 4}; `ex_ready`=1; `selection`=7 in the same cycle.
  - Response: 7 is accepted. The next head is 4, followed by 7.
- Duplicate:
  - Stimulus: s0 rid=9 stalled; `selection`=9.
  - Response: `sel_stall`=1, no push, `drop_count` increments.
- Flush:
  - Stimulus: cnt=2 and `flush`=1 together with `selection`=0x0A.
  - Response: the next cycle shows `ex_valid`=0 and no `out_set` pulse for rid 0x0A.
